alt_trigin_seq: RTL and testbench
=================================

ALT_TRIGIN_SEQ -- requirements
Module: alt_trigin_seq

Interface
REQ-001 SHALL have parameter: CYC_MAX, 124999999, highest legal cycles value of the timebase; tm_cyc_i wraps to 0 after it.
REQ-002 SHALL have ports, one per line, as follows:
 - clk_i  in  1  single system clock; all logic on its rising edge.
 - rst_n_i  in  1  reset, asynchronous, active-low.
 - en_wr_i  in  1  one-cycle write strobe for the control register.
 - en_dat_i  in  1  written enable bit, valid with en_wr_i.
 - enable_o  out  1  armed status, read back as the control enable bit.
 - tgt_sec_i  in  64  target seconds.
 - tgt_cyc_i  in  32  target cycles.
 - tm_sec_i  in  64  current timetag seconds.
 - tm_cyc_i  in  32  current timetag cycles.
 - tm_valid_i  in  1  timetag valid; no comparison while low.
 - trig_o  out  1  one-cycle trigger pulse.
 - late_o  out  1  sticky late-fire flag.
 - trig_cnt_o  out  32  count of fired triggers.

Function
REQ-003 SHALL implement FSM states IDLE, ARMED, FIRE.
REQ-004 SHALL capture tgt_sec_i/tgt_cyc_i into internal target registers on en_wr_i=1 with en_dat_i=1; later target input changes are ignored until the next arm.
REQ-005 SHALL go IDLE->ARMED, or ARMED->ARMED with re-captured target, on en_wr_i=1 with en_dat_i=1.
REQ-006 SHALL go to IDLE from any state on en_wr_i=1 with en_dat_i=0.
REQ-007 SHALL drive enable_o=1 exactly while the state is ARMED.
REQ-008 SHALL compare in two registered stages.
 - Stage 1: seconds eq/gt and cycles eq/gt, gated by ARMED and tm_valid_i.
 - Stage 2: combine the stage-1 results into a hit.
REQ-009 SHALL, on a timetag matching the fire condition sampled at edge N, enter FIRE and assert trig_o at edge N+2 for exactly one cycle.
REQ-010 SHALL clear enable_o at that same edge N+2.
REQ-011 SHALL return FIRE->IDLE after one cycle; no further triggers until re-armed.
REQ-012 SHALL increment trig_cnt_o by 1 per trig_o pulse, modulo 2^32.
REQ-013 SHALL give a control write precedence over a pending hit in the same cycle; the in-flight hit is discarded and does not pulse trig_o.
REQ-014 SHALL flush both compare stages on every arm or disarm write, so a hit requires two fresh comparisons after arming.
REQ-015 SHALL keep state ARMED while tm_valid_i=0, with no hit generated.
REQ-016 SHALL treat the timetag as the ordered pair (seconds, cycles), seconds most significant, unsigned.

Reset
REQ-017 SHALL, on rst_n_i low, immediately force the following, independent of clk_i:
 - state IDLE;
 - enable_o=0, trig_o=0, late_o=0, trig_cnt_o=0;
 - compare stages and target registers cleared.
REQ-018 SHALL abort any armed or in-flight trigger on reset with no trig_o pulse; the first arm is accepted on the first edge after release.

Configuration
REQ-019 SHALL, when ALT_TRIGIN_LATE_EN is defined:
 - fire on timetag >= target;
 - set late_o when firing with timetag strictly > target;
 - clear late_o on the next arm write.
REQ-020 SHALL, when ALT_TRIGIN_LATE_EN is not defined:
 - fire only on exact equality;
 - a passed target never fires;
 - tie late_o to 0.

Verification
REQ-021 Arm with target (5 s, 1000); timetag steps to (5, 1000) at edge N -> trig_o=1 at N+2 only, enable_o=0 from N+2, trig_cnt_o=1.
REQ-022 Arm, then disarm write at the same edge the timetag equals the target -> no trig_o, enable_o=0, trig_cnt_o unchanged.
REQ-023 Arm with target (5, 10); timetag jumps (5, 9)->(5, 12).
 - Macro on: trig_o after 2 cycles, late_o=1.
 - Macro off: no trig_o, stays armed, late_o=0.
REQ-024 Armed, tm_valid_i=0 while the timetag equals the target -> no trig_o; tm_valid_i=1 at the next matching value -> trig_o 2 cycles later.
REQ-025 Armed with a hit in stage 1; rst_n_i pulsed low mid-cycle -> outputs 0 immediately, no trig_o after release, trig_cnt_o=0.
REQ-026 trig_cnt_o preset via 2^32-1 fires -> next fire wraps trig_cnt_o to 0.

Source files
------------

// File: rtl/alt_trigin_seq.sv
// ============================================================================
//  Module   : alt_trigin_seq
//  Brief    : Armed timetag trigger; fires one pulse when the timebase reaches
//             a programmed (seconds, cycles) target. Define ALT_TRIGIN_LATE_EN
//             to fire on timetag >= target and flag late fires on late_o.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_trigin_seq #(
  parameter int unsigned CYC_MAX = 32'd124999999
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_wr_i,
  input  logic        en_dat_i,
  output logic        enable_o,
  input  logic [63:0] tgt_sec_i,
  input  logic [31:0] tgt_cyc_i,
  input  logic [63:0] tm_sec_i,
  input  logic [31:0] tm_cyc_i,
  input  logic        tm_valid_i,
  output logic        trig_o,
  output logic        late_o,
  output logic [31:0] trig_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] tgt_sec_q, tgt_sec_d;
  logic [31:0] tgt_cyc_q, tgt_cyc_d;
  logic        s1_vld_q, s1_vld_d;
  logic        sec_eq_q, sec_eq_d;
  logic        sec_gt_q, sec_gt_d;
  logic        cyc_eq_q, cyc_eq_d;
  logic        cyc_gt_q, cyc_gt_d;
  logic        hit_q, hit_d;
  logic        enable_q, enable_d;
  logic        trig_q, trig_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic        w_match;
`ifdef ALT_TRIGIN_LATE_EN
  logic        late_hit_q, late_hit_d;
  logic        late_q, late_d;
  logic        w_late;

  assign w_match = sec_gt_q | (sec_eq_q & (cyc_gt_q | cyc_eq_q));
  assign w_late  = sec_gt_q | (sec_eq_q & cyc_gt_q);
  assign late_o  = late_q;
`else
  // eq already excludes gt; gt terms keep both stage-1 flags meaningful
  assign w_match = sec_eq_q & cyc_eq_q & ~sec_gt_q & ~cyc_gt_q;
  assign late_o  = 1'b0;
`endif

  assign enable_o   = enable_q;
  assign trig_o     = trig_q;
  assign trig_cnt_o = trig_cnt_q;

  always_comb begin
    state_d    = state_q;
    tgt_sec_d  = tgt_sec_q;
    tgt_cyc_d  = tgt_cyc_q;
    trig_d     = 1'b0;
    trig_cnt_d = trig_cnt_q;
    s1_vld_d   = (state_q == ARMED) && tm_valid_i && (tm_cyc_i <= CYC_MAX);
    sec_eq_d   = (tm_sec_i == tgt_sec_q);
    sec_gt_d   = (tm_sec_i >  tgt_sec_q);
    cyc_eq_d   = (tm_cyc_i == tgt_cyc_q);
    cyc_gt_d   = (tm_cyc_i >  tgt_cyc_q);
    hit_d      = s1_vld_q && w_match;
`ifdef ALT_TRIGIN_LATE_EN
    late_hit_d = s1_vld_q && w_late;
    late_d     = late_q;
`endif

    case (state_q)
      ARMED: begin
        if (hit_q) begin
          state_d    = FIRE;
          trig_d     = 1'b1;
          trig_cnt_d = trig_cnt_q + 32'd1;
          s1_vld_d   = 1'b0;
          hit_d      = 1'b0;
`ifdef ALT_TRIGIN_LATE_EN
          late_d     = late_q | late_hit_q;
          late_hit_d = 1'b0;
`endif
        end
      end
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A control write overrides any fire decided above and restarts the pipe
    if (en_wr_i) begin
      trig_d     = 1'b0;
      trig_cnt_d = trig_cnt_q;
      s1_vld_d   = 1'b0;
      hit_d      = 1'b0;
`ifdef ALT_TRIGIN_LATE_EN
      late_hit_d = 1'b0;
      late_d     = en_dat_i ? 1'b0 : late_q;
`endif
      if (en_dat_i) begin
        state_d   = ARMED;
        tgt_sec_d = tgt_sec_i;
        tgt_cyc_d = tgt_cyc_i;
      end else begin
        state_d   = IDLE;
      end
    end

    enable_d = (state_d == ARMED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      tgt_sec_q  <= '0;
      tgt_cyc_q  <= '0;
      s1_vld_q   <= 1'b0;
      sec_eq_q   <= 1'b0;
      sec_gt_q   <= 1'b0;
      cyc_eq_q   <= 1'b0;
      cyc_gt_q   <= 1'b0;
      hit_q      <= 1'b0;
      enable_q   <= 1'b0;
      trig_q     <= 1'b0;
      trig_cnt_q <= '0;
`ifdef ALT_TRIGIN_LATE_EN
      late_hit_q <= 1'b0;
      late_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tgt_sec_q  <= tgt_sec_d;
      tgt_cyc_q  <= tgt_cyc_d;
      s1_vld_q   <= s1_vld_d;
      sec_eq_q   <= sec_eq_d;
      sec_gt_q   <= sec_gt_d;
      cyc_eq_q   <= cyc_eq_d;
      cyc_gt_q   <= cyc_gt_d;
      hit_q      <= hit_d;
      enable_q   <= enable_d;
      trig_q     <= trig_d;
      trig_cnt_q <= trig_cnt_d;
`ifdef ALT_TRIGIN_LATE_EN
      late_hit_q <= late_hit_d;
      late_q     <= late_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alt_trigin_seq.sv
// ============================================================================
//  Module   : tb_alt_trigin_seq
//  Brief    : Directed self-checking bench for alt_trigin_seq (both builds of
//             ALT_TRIGIN_LATE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alt_trigin_seq;

  logic        clk;
  logic        rst_n;
  logic        en_wr;
  logic        en_dat;
  logic        enable;
  logic [63:0] tgt_sec;
  logic [31:0] tgt_cyc;
  logic [63:0] tm_sec;
  logic [31:0] tm_cyc;
  logic        tm_valid;
  logic        trig;
  logic        late;
  logic [31:0] trig_cnt;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_cnt;

  alt_trigin_seq dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_wr_i    (en_wr),
    .en_dat_i   (en_dat),
    .enable_o   (enable),
    .tgt_sec_i  (tgt_sec),
    .tgt_cyc_i  (tgt_cyc),
    .tm_sec_i   (tm_sec),
    .tm_cyc_i   (tm_cyc),
    .tm_valid_i (tm_valid),
    .trig_o     (trig),
    .late_o     (late),
    .trig_cnt_o (trig_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_tm(input logic [63:0] s, input logic [31:0] c);
    tm_sec = s;
    tm_cyc = c;
  endtask

  task automatic arm(input logic [63:0] s, input logic [31:0] c);
    en_wr   = 1'b1;
    en_dat  = 1'b1;
    tgt_sec = s;
    tgt_cyc = c;
    tick();
    en_wr   = 1'b0;
    en_dat  = 1'b0;
    tgt_sec = '0;
    tgt_cyc = '0;
  endtask

  task automatic disarm();
    en_wr  = 1'b1;
    en_dat = 1'b0;
    tick();
    en_wr  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_wr = 1'b0; en_dat = 1'b0; tgt_sec = '0; tgt_cyc = '0;
    tm_sec = '0; tm_cyc = '0; tm_valid = 1'b0;
    exp_cnt = 32'd0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", enable); end
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("FAIL reset_late: got %b want 0", late); end
    n_checks++; if (trig_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", trig_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fire();
    tm_valid = 1'b1;
    set_tm(64'd5, 32'd999);
    arm(64'd5, 32'd1000);
    n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL basic_armed: enable got %b want 1", enable); end
    set_tm(64'd5, 32'd1000);
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL basic_trig_n: got %b want 0", trig); end
    set_tm(64'd5, 32'd1001);
    tick();
    n_checks++; if (trig !== 1'b0 || enable !== 1'b1) begin n_fail++; $display("FAIL basic_n1: trig/enable got %b%b want 01", trig, enable); end
    set_tm(64'd5, 32'd1002);
    tick();
    exp_cnt = 32'd1;
    n_checks++; if (trig !== 1'b1) begin n_fail++; $display("FAIL basic_trig_n2: got %b want 1", trig); end
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL basic_enable_n2: got %b want 0", enable); end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
    set_tm(64'd5, 32'd1003);
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b want 0", trig); end
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("FAIL basic_late: got %b want 0", late); end
  endtask

  task automatic test_disarm_same_edge();
    set_tm(64'd5, 32'd1990);
    arm(64'd5, 32'd2000);
    set_tm(64'd5, 32'd2000);
    disarm();
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL disarm_enable: got %b want 0", enable); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL disarm_trig[%0d]: got %b want 0", i, trig); end
      tick();
    end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL disarm_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
  endtask

  task automatic test_write_precedence();
    set_tm(64'd5, 32'd2990);
    arm(64'd5, 32'd3000);
    set_tm(64'd5, 32'd3000);
    tick();
    tick();
    disarm();
    n_checks++; if (trig !== 1'b0 || enable !== 1'b0) begin n_fail++; $display("FAIL precedence_n2: trig/enable got %b%b want 00", trig, enable); end
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL precedence_n3: got %b want 0", trig); end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL precedence_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
  endtask

  task automatic test_rearm_flush();
    set_tm(64'd5, 32'd4000);
    arm(64'd5, 32'd4000);
    tick();
    arm(64'd5, 32'd4000);
    n_checks++; if (enable !== 1'b1 || trig !== 1'b0) begin n_fail++; $display("FAIL rearm_state: trig/enable got %b%b want 01", trig, enable); end
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rearm_early_a: got %b want 0", trig); end
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rearm_early_b: got %b want 0", trig); end
    tick();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (trig !== 1'b1) begin n_fail++; $display("FAIL rearm_fire: got %b want 1", trig); end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL rearm_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rearm_no_refire: got %b want 0", trig); end
  endtask

  task automatic test_late();
    logic exp_fire;
`ifdef ALT_TRIGIN_LATE_EN
    exp_fire = 1'b1;
`else
    exp_fire = 1'b0;
`endif
    set_tm(64'd5, 32'd8);
    arm(64'd5, 32'd10);
    set_tm(64'd5, 32'd9);
    tick();
    set_tm(64'd5, 32'd12);
    tick();
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL late_n1: got %b want 0", trig); end
    tick();
    if (exp_fire) exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (trig !== exp_fire) begin n_fail++; $display("FAIL late_trig: got %b want %b", trig, exp_fire); end
    n_checks++; if (late !== exp_fire) begin n_fail++; $display("FAIL late_flag: got %b want %b", late, exp_fire); end
    n_checks++; if (enable !== !exp_fire) begin n_fail++; $display("FAIL late_enable: got %b want %b", enable, !exp_fire); end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL late_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL late_after: got %b want 0", trig); end
    arm(64'd5, 32'd20);
    n_checks++; if (late !== 1'b0) begin n_fail++; $display("FAIL late_clear_on_arm: got %b want 0", late); end
    disarm();
  endtask

  task automatic test_valid_gate();
    tm_valid = 1'b0;
    set_tm(64'd6, 32'd100);
    arm(64'd6, 32'd100);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (trig !== 1'b0 || enable !== 1'b1) begin n_fail++; $display("FAIL valid_low[%0d]: trig/enable got %b%b want 01", i, trig, enable); end
    end
    tm_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL valid_m1: got %b want 0", trig); end
    tick();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (trig !== 1'b1) begin n_fail++; $display("FAIL valid_fire: got %b want 1", trig); end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL valid_cnt: got %0d want %0d", trig_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    set_tm(64'd7, 32'd50);
    arm(64'd7, 32'd50);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_enable: got %b want 0", enable); end
    n_checks++; if (trig_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", trig_cnt); end
    n_checks++; if (trig !== 1'b0 || late !== 1'b0) begin n_fail++; $display("FAIL rstmid_trig_late: got %b%b want 00", trig, late); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (trig !== 1'b0 || enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_after[%0d]: trig/enable got %b%b want 00", i, trig, enable); end
    end
    n_checks++; if (trig_cnt !== exp_cnt) begin n_fail++; $display("FAIL rstmid_cnt_after: got %0d want 0", trig_cnt); end
  endtask

  task automatic test_cnt_wrap();
    force dut.trig_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.trig_cnt_q;
    n_checks++; if (trig_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset: got %h want ffffffff", trig_cnt); end
    @(negedge clk);
    set_tm(64'd8, 32'd1);
    arm(64'd8, 32'd1);
    tick();
    tick();
    tick();
    n_checks++; if (trig !== 1'b1) begin n_fail++; $display("FAIL wrap_fire: got %b want 1", trig); end
    n_checks++; if (trig_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %h want 00000000", trig_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_fire();
    test_disarm_same_edge();
    test_write_precedence();
    test_rearm_flush();
    test_late();
    test_valid_gate();
    test_reset_mid();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
